alu_rr_sched: RTL and testbench
===============================

Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one registered ALU (ops ADD/SUB/MUL/DIV/AND/XOR, 16-bit result, carry and zero flags) between NUM_REQ requesters.
- Accepts one operation at a time over a valid/ready handshake, drives the ALU operand and opcode inputs, and waits out the ALU's registered latency.
- Returns the result, flags and requester id on a single valid/ready response port.
- Sits directly in front of the ALU instance in the ALU subsystem top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand width; result width is 2*DATA_W.
- OP_W, 4, opcode width.
- ALU_LAT, 1, ALU cycles from input-stable edge to registered output (1..4).

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_A  input  NUM_REQ*DATA_W  packed operand A; slice i belongs to requester i.
- req_B  input  NUM_REQ*DATA_W  packed operand B.
- req_op  input  NUM_REQ*OP_W  packed opcodes.
- req_cin  input  NUM_REQ  carry-in, used by ADD only.
- alu_A  output  DATA_W  operand A to ALU.
- alu_B  output  DATA_W  operand B to ALU.
- alu_op_code  output  OP_W  opcode to ALU.
- alu_C_in  output  1  carry-in to ALU.
- alu_Result  input  2*DATA_W  ALU registered result.
- alu_C_out  input  1  ALU carry flag.
- alu_Z_flag  input  1  ALU zero flag.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  $clog2(NUM_REQ)  id of the requester that owns the response.
- rsp_result  output  2*DATA_W  result.
- rsp_c_out  output  1  carry flag.
- rsp_z_flag  output  1  zero flag.
- rsp_err  output  1  operation rejected (see Optional Feature).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE; all outputs 0 (req_ready, rsp_*, busy, alu_*).
  - RR pointer set to NUM_REQ-1, so requester 0 has highest priority first.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready is one-hot to the first requester with req_valid, searching from pointer+1 with wrap-around. It is a combinational function of req_valid and the pointer.
  - When req_valid[g] and req_ready[g] are both high, latch A/B/op/cin and id g, set pointer := g, go to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE (1 cycle):
  - Drive alu_* from the latched values. alu_* stay stable through ISSUE and WAIT.
- WAIT (ALU_LAT cycles, counted by a down-counter):
  - On the final WAIT cycle, sample alu_Result/alu_C_out/alu_Z_flag into the response registers; go to RESP.
- RESP:
  - rsp_valid=1 with rsp_* stable until rsp_ready. The handshake cycle returns to IDLE.
  - req_ready stays 0 outside IDLE; a new accept can happen the cycle after the response handshake.
- alu_* are driven to 0 in IDLE and RESP.
- Latency: accept edge to rsp_valid = ALU_LAT+2 cycles. Throughput is 1 operation per ALU_LAT+3 cycles with rsp_ready held high.
- Requesters must hold req_* stable while req_valid is high and not accepted. Dropping req_valid before acceptance is legal; that requester is simply skipped.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0…; no requester waits more than NUM_REQ-1 grants.
- Reset mid-operation (any state): the in-flight operation is discarded and no response is produced. The ALU's own reset is handled at the subsystem top.

Optional Feature:
- Macro ALU_OPCHK_EN.
- Defined:
  - In IDLE, an accepted op with opcode > 5, or DIV with B == 0, skips ISSUE/WAIT and goes straight to RESP.
  - Response: rsp_err=1, rsp_result=0, rsp_c_out=0, rsp_z_flag=0. The ALU is not driven.
  - Accept-to-valid latency for a rejected op is 1 cycle.
- Undefined: every op is issued to the ALU; rsp_err is tied to 0.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_AND=4, OP_XOR=5, and OP_LAST=5.
  - sched_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - default width constants.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs one-hot gnt[N] and encoded gnt_id. Purely combinational; the pointer register lives in alu_rr_sched.

Test Plan:
- Single request: req0 A=8'h0F, B=8'h01, op=0, cin=1; ALU returns 16'h0011 -> rsp_id=0, rsp_result=16'h0011, rsp_z_flag=0; rsp_valid rises 3 cycles after accept (ALU_LAT=1).
- All four requesters valid continuously, each doing MUL 8'h10*8'h10 -> grant order 0,1,2,3,0; each rsp_result=16'h0100 with the matching rsp_id.
- Backpressure: rsp_ready=0 for 5 cycles while in RESP -> rsp_* held stable, req_ready all 0; rsp_ready=1 -> IDLE next cycle, then the next grant is issued.
- Zero result: AND 8'hF0 & 8'h0F -> rsp_result=0, rsp_z_flag=1, rsp_c_out=0.
- Reset asserted during WAIT -> all outputs 0 immediately (asynchronously); after release, requester 0 wins first despite the previous pointer.
- ALU_OPCHK_EN defined: req2 op=4'd9, then req2 DIV with B=0 -> rsp_err=1, rsp_id=2, rsp_result=0, and alu_op_code stays 0 throughout.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the ALU round-robin scheduler.
package alu_pkg;
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_MUL  = 2;
  localparam int unsigned OP_DIV  = 3;
  localparam int unsigned OP_AND  = 4;
  localparam int unsigned OP_XOR  = 5;
  localparam int unsigned OP_LAST = 5;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_OP_W    = 4;
  localparam int DEF_ALU_LAT = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr (with wrap) wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);
  always_comb begin
    logic found;
    int   idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one registered ALU between NUM_REQ requesters.
// Optional opcode screening is enabled by defining ALU_OPCHK_EN.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int ALU_LAT = DEF_ALU_LAT,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic                             CLK,
  input  logic                             Reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_A,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_B,
  input  logic [NUM_REQ-1:0][OP_W-1:0]     req_op,
  input  logic [NUM_REQ-1:0]               req_cin,
  output logic [DATA_W-1:0]                alu_A,
  output logic [DATA_W-1:0]                alu_B,
  output logic [OP_W-1:0]                  alu_op_code,
  output logic                             alu_C_in,
  input  logic [2*DATA_W-1:0]              alu_Result,
  input  logic                             alu_C_out,
  input  logic                             alu_Z_flag,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [IW-1:0]                    rsp_id,
  output logic [2*DATA_W-1:0]              rsp_result,
  output logic                             rsp_c_out,
  output logic                             rsp_z_flag,
  output logic                             rsp_err,
  output logic                             busy
);
  sched_state_t        r_state;
  logic [IW-1:0]       r_ptr, r_id;
  logic [DATA_W-1:0]   r_a, r_b;
  logic [OP_W-1:0]     r_op;
  logic                r_cin;
  logic [2:0]          r_cnt;
  logic [2*DATA_W-1:0] r_res;
  logic                r_c, r_z;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [IW-1:0]       w_gnt_id;
  logic                w_accept, w_drive;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req    (req_valid),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  // Ready is gated by Reset so every output reads 0 while reset is held.
  assign req_ready = (r_state == IDLE && Reset) ? w_gnt : '0;
  assign w_accept  = |(req_valid & req_ready);

`ifdef ALU_OPCHK_EN
  logic r_err, w_rej;
  assign w_rej = (req_op[w_gnt_id] > OP_W'(OP_LAST)) ||
                 (req_op[w_gnt_id] == OP_W'(OP_DIV) && req_B[w_gnt_id] == '0);
  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cin   <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
`ifdef ALU_OPCHK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_ptr <= w_gnt_id;
          r_id  <= w_gnt_id;
          r_a   <= req_A[w_gnt_id];
          r_b   <= req_B[w_gnt_id];
          r_op  <= req_op[w_gnt_id];
          r_cin <= req_cin[w_gnt_id];
`ifdef ALU_OPCHK_EN
          r_err <= w_rej;
          if (w_rej) begin
            r_res   <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_state <= RESP;
          end else begin
            r_state <= ISSUE;
          end
`else
          r_state <= ISSUE;
`endif
        end
        ISSUE: begin
          r_cnt   <= 3'(ALU_LAT - 1);
          r_state <= WAIT;
        end
        WAIT: if (r_cnt == '0) begin
          r_res   <= alu_Result;
          r_c     <= alu_C_out;
          r_z     <= alu_Z_flag;
          r_state <= RESP;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
        RESP: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_drive     = (r_state == ISSUE) || (r_state == WAIT);
  assign alu_A       = w_drive ? r_a   : '0;
  assign alu_B       = w_drive ? r_b   : '0;
  assign alu_op_code = w_drive ? r_op  : '0;
  assign alu_C_in    = w_drive ? r_cin : 1'b0;

  assign rsp_valid  = (r_state == RESP);
  assign rsp_id     = r_id;
  assign rsp_result = r_res;
  assign rsp_c_out  = r_c;
  assign rsp_z_flag = r_z;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched with a one-cycle registered ALU model.
module tb_alu_rr_sched;
  localparam int NR = 4, DW = 8, OW = 4, IW = 2;

  logic                   CLK = 1'b0, Reset = 1'b0;
  logic [NR-1:0]          req_valid = '0, req_ready, req_cin = '0;
  logic [NR-1:0][DW-1:0]  req_A = '0, req_B = '0;
  logic [NR-1:0][OW-1:0]  req_op = '0;
  logic [DW-1:0]          alu_A, alu_B;
  logic [OW-1:0]          alu_op_code;
  logic                   alu_C_in, alu_C_out = 1'b0, alu_Z_flag = 1'b0;
  logic [2*DW-1:0]        alu_Result = '0, rsp_result;
  logic                   rsp_valid, rsp_ready = 1'b0, rsp_c_out, rsp_z_flag, rsp_err, busy;
  logic [IW-1:0]          rsp_id;
  int n_cmp = 0, n_bad = 0;

  always #5 CLK = ~CLK;

  alu_rr_sched #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW), .ALU_LAT(1)) dut (
    .CLK(CLK), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_op(req_op), .req_cin(req_cin),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op_code(alu_op_code), .alu_C_in(alu_C_in),
    .alu_Result(alu_Result), .alu_C_out(alu_C_out), .alu_Z_flag(alu_Z_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_c_out(rsp_c_out), .rsp_z_flag(rsp_z_flag),
    .rsp_err(rsp_err), .busy(busy)
  );

  // Registered ALU stand-in (latency 1)
  always @(posedge CLK) begin
    logic [2*DW-1:0] r;
    case (alu_op_code)
      4'd0: r = {8'h00, alu_A} + {8'h00, alu_B} + {15'd0, alu_C_in};
      4'd1: r = {8'h00, alu_A} - {8'h00, alu_B};
      4'd2: r = alu_A * alu_B;
      4'd3: r = (alu_B != 0) ? {8'h00, alu_A / alu_B} : '0;
      4'd4: r = {8'h00, alu_A & alu_B};
      4'd5: r = {8'h00, alu_A ^ alu_B};
      default: r = '0;
    endcase
    alu_Result <= r;
    alu_C_out  <= (alu_op_code == 4'd0) ? r[DW] : 1'b0;
    alu_Z_flag <= (r == '0);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk({tag, "_rsp_to"}, 32'(rsp_valid), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk({tag, "_idle_to"}, 32'(busy), 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_rv", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu", {alu_A, alu_B, alu_op_code, 3'b0, alu_C_in}, 0);
    @(negedge CLK); Reset = 1'b1;

    // Single ADD from req0, timing check
    req_A[0] = 8'h0F; req_B[0] = 8'h01; req_op[0] = 4'd0; req_cin[0] = 1'b1;
    req_valid = 4'b0001;
    #1 chk("s_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    chk("s_issue_A", 32'(alu_A), 32'h0F);
    chk("s_issue_cin", 32'(alu_C_in), 1);
    tick(); chk("s_wait_rv", 32'(rsp_valid), 0);
    tick(); chk("s_lat_rv", 32'(rsp_valid), 1);
    chk("s_id", 32'(rsp_id), 0);
    chk("s_res", 32'(rsp_result), 32'h0011);
    chk("s_z", 32'(rsp_z_flag), 0);
    chk("s_err", 32'(rsp_err), 0);
    chk("s_alu_resp", 32'(alu_op_code), 0);
    rsp_ready = 1'b1; tick();
    chk("s_back_idle", 32'(busy), 0);

    // Fairness: reset pointer first, then all four MUL continuously
    Reset = 1'b0; #1 Reset = 1'b1;
    for (int i = 0; i < NR; i++) begin
      req_A[i] = 8'h10; req_B[i] = 8'h10; req_op[i] = 4'd2; req_cin[i] = 1'b0;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_idle("rr");
      #1 chk($sformatf("rr_gnt%0d", k), 32'(req_ready), 32'(1 << (k % NR)));
      tick();
      wait_rsp("rr");
      chk($sformatf("rr_id%0d", k), 32'(rsp_id), 32'(k % NR));
      chk($sformatf("rr_res%0d", k), 32'(rsp_result), 32'h0100);
      tick();
    end
    req_valid = '0;

    // Backpressure: req1 SUB held in RESP, req2 AND queued behind it
    rsp_ready = 1'b0;
    req_A[1] = 8'h20; req_B[1] = 8'h05; req_op[1] = 4'd1;
    req_A[2] = 8'hF0; req_B[2] = 8'h0F; req_op[2] = 4'd4;
    req_valid = 4'b0110;
    #1 chk("bp_gnt", 32'(req_ready), 32'b0010);
    tick(); req_valid = 4'b0100;
    wait_rsp("bp");
    for (int k = 0; k < 5; k++) begin
      chk("bp_rv", 32'(rsp_valid), 1);
      chk("bp_res", 32'(rsp_result), 32'h001B);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_rdy", 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1; tick();
    chk("bp_idle", 32'(busy), 0);
    chk("bp_next_gnt", 32'(req_ready), 32'b0100);
    tick(); req_valid = '0;
    wait_rsp("zr");
    chk("zr_id", 32'(rsp_id), 2);
    chk("zr_res", 32'(rsp_result), 0);
    chk("zr_z", 32'(rsp_z_flag), 1);
    chk("zr_c", 32'(rsp_c_out), 0);
    tick();

    // Reset in WAIT while req0 in flight (pointer would otherwise favour req1)
    req_A[0] = 8'h33; req_B[0] = 8'h44; req_op[0] = 4'd5; req_cin[0] = 1'b0;
    req_valid = 4'b0001;
    #1 chk("rw_gnt", 32'(req_ready), 32'b0001);
    tick(); req_valid = '0;
    tick();
    Reset = 1'b0;
    #1;
    chk("rw_rv", 32'(rsp_valid), 0);
    chk("rw_busy", 32'(busy), 0);
    chk("rw_alu", {alu_A, alu_B, alu_op_code, 3'b0, alu_C_in}, 0);
    req_valid = 4'b0011;
    #1 chk("rw_rdy_in_rst", 32'(req_ready), 0);
    @(negedge CLK); Reset = 1'b1;
    #1 chk("rw_gnt_after", 32'(req_ready), 32'b0001);
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rw_no_rsp", 32'(rsp_valid), 0);
    end

`ifdef ALU_OPCHK_EN
    // Illegal opcode and divide by zero are answered without the ALU
    req_A[2] = 8'h12; req_B[2] = 8'h00; req_op[2] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) req_op[2] = 4'd3;
      req_valid = 4'b0100;
      #1 chk("oc_gnt", 32'(req_ready), 32'b0100);
      tick(); req_valid = '0;
      chk("oc_rv", 32'(rsp_valid), 1);
      chk("oc_err", 32'(rsp_err), 1);
      chk("oc_id", 32'(rsp_id), 2);
      chk("oc_res", {rsp_result, 14'd0, rsp_c_out, rsp_z_flag}, 0);
      chk("oc_alu", 32'(alu_op_code), 0);
      tick();
      chk("oc_alu2", 32'(alu_op_code), 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
